// File: rtl/axis_multi_pattern_generator_pkg.sv
// Shared types and constants for the multi-pattern AXI-Stream generator.
// Mode encodings, generator FSM states and the default LFSR feedback mask.
package axis_multi_pattern_generator_pkg;

    localparam logic [1:0] MODE_CNT   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h80200003;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } gen_state_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// When empty, the output keeps the last word that was read out.
module axis_sync_fifo #(
    parameter int WIDTH      = 33,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [ADDR_WIDTH:0]   o_level
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [WIDTH-1:0]      r_hold;
    logic [ADDR_WIDTH:0]   w_level;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr;
    logic                  w_rd;
    logic [WIDTH-1:0]      w_head;

    // Extra pointer bit distinguishes full from empty.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = w_level[ADDR_WIDTH];
    assign w_empty = (w_level == '0);
    assign w_wr    = i_wr_en & ~w_full;
    assign w_rd    = i_rd_en & ~w_empty;
    assign w_head  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
        end
    end

    // Read/write pointers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Remember the last word popped so the output holds while empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (w_rd) begin
            r_hold <= w_head;
        end
    end

    assign o_rd_data = w_empty ? r_hold : w_head;
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_level   = w_level;

endmodule

// File: rtl/axis_multi_pattern_generator.sv
// AXI-Stream master producing framed packets of selectable data patterns.
// Generator FSM feeds an FWFT FIFO; packets always finish once started.
module axis_multi_pattern_generator
    import axis_multi_pattern_generator_pkg::*;
#(
    parameter int          DATA_SIZE     = 32,
    parameter int          ADDR_WIDTH    = 4,
    parameter int          PKT_LEN_WIDTH = 8,
    parameter logic [31:0] LFSR_TAPS     = DEFAULT_LFSR_TAPS
) (
    input  logic                       m00_axis_aclk,
    input  logic                       m00_axis_areset,
    input  logic                       m00_axis_enable,
    input  logic [1:0]                 m00_axis_mode,
    input  logic [DATA_SIZE-1:0]       m00_axis_seed,
    input  logic [PKT_LEN_WIDTH-1:0]   m00_axis_pkt_len,
    input  logic                       m00_axis_tready,
    output logic [DATA_SIZE-1:0]       m00_axis_tdata,
    output logic [DATA_SIZE/8-1:0]     m00_axis_tstrb,
    output logic                       m00_axis_tvalid,
    output logic                       m00_axis_tlast,
    output logic [ADDR_WIDTH:0]        m00_axis_fifo_level,
    output logic [15:0]                m00_axis_pkt_count
);

    localparam logic [DATA_SIZE-1:0] TAPS = DATA_SIZE'(LFSR_TAPS);

    gen_state_t                r_state;
    gen_state_t                w_next;
    logic [1:0]                r_mode;
    logic [PKT_LEN_WIDTH-1:0]  r_len;
    logic [PKT_LEN_WIDTH-1:0]  r_beat;
    logic [DATA_SIZE-1:0]      r_pattern;
    logic                      r_first;
    logic [15:0]               r_pkt_count;
    logic [PKT_LEN_WIDTH-1:0]  w_len_in;
    logic [DATA_SIZE-1:0]      w_pat_next;
    logic [DATA_SIZE-1:0]      w_pat_init;
    logic [DATA_SIZE-1:0]      w_seed_nz;
    logic                      w_last;
    logic                      w_wr;
    logic                      w_full;
    logic                      w_empty;
    logic [DATA_SIZE:0]        w_fifo_out;

    function automatic logic [DATA_SIZE-1:0] f_lfsr(
        input logic [DATA_SIZE-1:0] v
    );
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    assign w_len_in  = (m00_axis_pkt_len == '0) ?
                       PKT_LEN_WIDTH'(1) : m00_axis_pkt_len;
    assign w_seed_nz = (m00_axis_seed == '0) ?
                       DATA_SIZE'(1) : m00_axis_seed;
    assign w_last    = (r_beat == r_len - PKT_LEN_WIDTH'(1));
    assign w_wr      = (r_state == RUN) && !w_full;

    // Next-state decode; a packet only ends on its last accepted write.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (m00_axis_enable) w_next = LOAD;
            LOAD: w_next = RUN;
            RUN: begin
                if (w_wr && w_last) begin
                    w_next = m00_axis_enable ? LOAD : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Pattern start value and per-beat advance.
    always_comb begin
        w_pat_init = m00_axis_seed;
        w_pat_next = r_pattern;
        unique case (m00_axis_mode)
            MODE_LFSR: w_pat_init = f_lfsr(w_seed_nz);
            MODE_WALK: w_pat_init = DATA_SIZE'(1);
            default:   w_pat_init = m00_axis_seed;
        endcase
        unique case (r_mode)
            MODE_CNT:  w_pat_next = r_pattern + DATA_SIZE'(1);
            MODE_LFSR: w_pat_next = f_lfsr(r_pattern);
            MODE_WALK: w_pat_next = {r_pattern[DATA_SIZE-2:0],
                                     r_pattern[DATA_SIZE-1]};
            default:   w_pat_next = r_pattern;
        endcase
    end

    // FSM state register.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) r_state <= IDLE;
        else                 r_state <= w_next;
    end

    // Packet parameters, pattern register and beat counter.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            r_mode    <= MODE_CNT;
            r_len     <= PKT_LEN_WIDTH'(1);
            r_beat    <= '0;
            r_pattern <= '0;
            r_first   <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: r_first <= 1'b1;
                LOAD: begin
                    r_mode  <= m00_axis_mode;
                    r_len   <= w_len_in;
                    r_beat  <= '0;
                    r_first <= 1'b0;
                    if (r_first) r_pattern <= w_pat_init;
                end
                RUN: begin
                    if (w_wr) begin
                        r_pattern <= w_pat_next;
                        r_beat    <= w_last ? '0 : r_beat + 1'b1;
                    end
                end
                default: r_first <= 1'b1;
            endcase
        end
    end

    // Count packets whose final beat was taken downstream.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            r_pkt_count <= '0;
        end else if (!w_empty && m00_axis_tready && w_fifo_out[DATA_SIZE]) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    axis_sync_fifo #(
        .WIDTH      (DATA_SIZE + 1),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .i_clk     (m00_axis_aclk),
        .i_rst     (m00_axis_areset),
        .i_wr_en   (w_wr),
        .i_wr_data ({w_last, r_pattern}),
        .i_rd_en   (m00_axis_tready),
        .o_rd_data (w_fifo_out),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_level   (m00_axis_fifo_level)
    );

    assign m00_axis_tdata     = w_fifo_out[DATA_SIZE-1:0];
    assign m00_axis_tlast     = w_fifo_out[DATA_SIZE];
    assign m00_axis_tvalid    = !w_empty;
    assign m00_axis_tstrb     = '1;
    assign m00_axis_pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis_multi_pattern_generator.sv
// Self-checking bench for axis_multi_pattern_generator.
// Expected streams come from a pattern-rule model indexed by beat number.
module tb_axis_multi_pattern_generator;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [1:0]      mode;
    logic [DW-1:0]   seed;
    logic [LW-1:0]   plen;
    logic            tready;
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tstrb;
    logic            tvalid;
    logic            tlast;
    logic [AW:0]     level;
    logic [15:0]     pkt_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pkts = 0;

    logic [DW:0] got_q[$];
    logic [DW:0] exp_q[$];

    always #5 clk = ~clk;

    axis_multi_pattern_generator #(
        .DATA_SIZE     (DW),
        .ADDR_WIDTH    (AW),
        .PKT_LEN_WIDTH (LW),
        .LFSR_TAPS     (32'h80200003)
    ) dut (
        .m00_axis_aclk       (clk),
        .m00_axis_areset     (rst),
        .m00_axis_enable     (en),
        .m00_axis_mode       (mode),
        .m00_axis_seed       (seed),
        .m00_axis_pkt_len    (plen),
        .m00_axis_tready     (tready),
        .m00_axis_tdata      (tdata),
        .m00_axis_tstrb      (tstrb),
        .m00_axis_tvalid     (tvalid),
        .m00_axis_tlast      (tlast),
        .m00_axis_fifo_level (level),
        .m00_axis_pkt_count  (pkt_count)
    );

    // Record every accepted beat, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && tvalid && tready) got_q.push_back({tlast, tdata});
    end

    // Value of beat k (counted from the pattern start).
    function automatic logic [DW-1:0] pat_val(
        input logic [1:0] m, input logic [DW-1:0] s, input int k
    );
        logic [DW-1:0] v;
        case (m)
            2'd0: return s + DW'(k);
            2'd1: begin
                v = (s == 0) ? 32'd1 : s;
                repeat (k + 1) v = (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
                return v;
            end
            2'd2: return 32'h1 << (k % DW);
            default: return s;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp(
        input logic [1:0] m, input logic [DW-1:0] s,
        input logic [LW-1:0] len, input int npkts
    );
        int L;
        logic lst;
        L = (len == 0) ? 1 : int'(len);
        for (int p = 0; p < npkts; p++) begin
            for (int i = 0; i < L; i++) begin
                lst = (i == L - 1);
                exp_q.push_back({lst, pat_val(m, s, p * L + i)});
            end
        end
        exp_pkts += npkts;
    endtask

    task automatic start_pkt(
        input logic [1:0] m, input logic [DW-1:0] s,
        input logic [LW-1:0] len, input int hold
    );
        mode = m;
        seed = s;
        plen = len;
        en   = 1'b1;
        repeat (hold) tick;
        en = 1'b0;
    endtask

    task automatic wait_beats(input int n, input bit rnd);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < 2000) begin
            if (rnd) tready = 1'($urandom_range(0, 1));
            tick;
            cyc++;
        end
        tready = 1'b1;
        repeat (4) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_tvalid: got %b required 0", tvalid);
        end
        n_checks++;
        if (tdata !== '0) begin
            n_fail++; $display("FAIL rst_tdata: got %h required 0", tdata);
        end
        n_checks++;
        if (tlast !== 1'b0) begin
            n_fail++; $display("FAIL rst_tlast: got %b required 0", tlast);
        end
        n_checks++;
        if (tstrb !== 4'hF) begin
            n_fail++; $display("FAIL rst_tstrb: got %h required f", tstrb);
        end
        n_checks++;
        if (level !== '0) begin
            n_fail++; $display("FAIL rst_level: got %0d required 0", level);
        end
        n_checks++;
        if (pkt_count !== 16'd0) begin
            n_fail++; $display("FAIL rst_pktcnt: got %0d required 0", pkt_count);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_counter;
        got_q.delete(); exp_q.delete();
        build_exp(2'd0, 32'd5, 8'd4, 1);
        start_pkt(2'd0, 32'd5, 8'd4, 1);
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++; $display("FAIL lat_load: tvalid %b required 0", tvalid);
        end
        tick;
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++; $display("FAIL lat_run: tvalid %b required 0", tvalid);
        end
        tick;
        n_checks++;
        if (tvalid !== 1'b1) begin
            n_fail++; $display("FAIL lat_first: tvalid %b required 1", tvalid);
        end
        wait_beats(exp_q.size(), 1'b0);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL cnt_len: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL cnt_beat%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        n_checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            n_fail++; $display("FAIL cnt_pkts: got %0d required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_lfsr;
        got_q.delete(); exp_q.delete();
        build_exp(2'd1, 32'd1, 8'd3, 1);
        start_pkt(2'd1, 32'd1, 8'd3, 1);
        wait_beats(exp_q.size(), 1'b0);
        build_exp(2'd1, 32'd0, 8'd3, 1);
        start_pkt(2'd1, 32'd0, 8'd3, 1);
        wait_beats(exp_q.size(), 1'b0);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL lfsr_len: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL lfsr_beat%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        if (got_q.size() >= 2) begin
            n_checks++;
            if (got_q[0][DW-1:0] !== 32'h80200003 || got_q[1][DW-1:0] !== 32'hC0300002) begin
                n_fail++;
                $display("FAIL lfsr_const: got %h %h required 80200003 c0300002",
                         got_q[0][DW-1:0], got_q[1][DW-1:0]);
            end
        end
        n_checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            n_fail++; $display("FAIL lfsr_pkts: got %0d required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] s;
        s = $urandom;
        got_q.delete(); exp_q.delete();
        build_exp(2'd0, s, 8'd40, 1);
        tready = 1'b0;
        start_pkt(2'd0, s, 8'd40, 1);
        repeat (20) tick;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (tvalid !== 1'b1 || tdata !== s || tlast !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v%b d%h l%b required v1 d%h l0",
                         c, tvalid, tdata, tlast, s);
            end
            tick;
        end
        n_checks++;
        if (level !== 5'd16) begin
            n_fail++; $display("FAIL bp_level: got %0d required 16", level);
        end
        tready = 1'b1;
        wait_beats(exp_q.size(), 1'b0);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_len: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        n_checks++;
        if (level !== '0 || tvalid !== 1'b0) begin
            n_fail++; $display("FAIL bp_drain: got level %0d v%b required 0 0", level, tvalid);
        end
    endtask

    task automatic test_enable_drop;
        logic [DW-1:0] s;
        s = $urandom;
        got_q.delete(); exp_q.delete();
        build_exp(2'd0, s, 8'd8, 1);
        start_pkt(2'd0, s, 8'd8, 3);
        wait_beats(exp_q.size(), 1'b0);
        repeat (10) tick;
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL drop_len: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL drop_beat%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        n_checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            n_fail++; $display("FAIL drop_pkts: got %0d required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] s;
        int cyc;
        s = $urandom;
        got_q.delete(); exp_q.delete();
        start_pkt(2'd0, s, 8'd6, 1);
        cyc = 0;
        while (got_q.size() < 2 && cyc < 100) begin
            tick;
            cyc++;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++;
        if (tvalid !== 1'b0 || level !== '0 || pkt_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rmid_state: got v%b level %0d pkts %0d required 0 0 0",
                     tvalid, level, pkt_count);
        end
        got_q.delete(); exp_q.delete();
        exp_pkts = 0;
        tick;
        build_exp(2'd0, s, 8'd6, 1);
        start_pkt(2'd0, s, 8'd6, 1);
        wait_beats(exp_q.size(), 1'b0);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rmid_len: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rmid_beat%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        n_checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            n_fail++; $display("FAIL rmid_pkts: got %0d required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_walk_and_zero_len;
        logic [DW-1:0] s;
        s = $urandom;
        got_q.delete(); exp_q.delete();
        build_exp(2'd2, s, 8'd40, 1);
        start_pkt(2'd2, s, 8'd40, 1);
        wait_beats(exp_q.size(), 1'b0);
        for (int k = 0; k < 2; k++) begin
            build_exp(2'd0, s, 8'd0, 1);
            start_pkt(2'd0, s, 8'd0, 1);
            wait_beats(exp_q.size(), 1'b0);
        end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL walk_len: got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL walk_beat%0d: got %h required %h", i,
                         (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
            end
        end
        n_checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            n_fail++; $display("FAIL walk_pkts: got %0d required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] s;
        logic [1:0]    m;
        int            L;
        for (int it = 0; it < 3; it++) begin
            s = $urandom;
            m = 2'($urandom_range(0, 3));
            L = $urandom_range(1, 6);
            got_q.delete(); exp_q.delete();
            build_exp(m, s, LW'(L), 3);
            start_pkt(m, s, LW'(L), 2 * (L + 1) + 1);
            wait_beats(exp_q.size(), 1'b0);
            repeat (6) tick;
            n_checks++;
            if (got_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL b2b%0d_len: got %0d beats required %0d",
                         it, got_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                n_checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b%0d_beat%0d: got %h required %h", it, i,
                             (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
                end
            end
        end
        n_checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            n_fail++; $display("FAIL b2b_pkts: got %0d required %0d", pkt_count, exp_pkts);
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] s;
        logic [1:0]    m;
        logic [LW-1:0] len;
        for (int it = 0; it < 8; it++) begin
            s   = $urandom;
            m   = 2'($urandom_range(0, 3));
            len = LW'($urandom_range(0, 24));
            got_q.delete(); exp_q.delete();
            build_exp(m, s, len, 1);
            start_pkt(m, s, len, 1);
            wait_beats(exp_q.size(), 1'b1);
            n_checks++;
            if (got_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rnd%0d_len: got %0d beats required %0d",
                         it, got_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) begin
                n_checks++;
                if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_beat%0d: got %h required %h", it, i,
                             (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
                end
            end
        end
        n_checks++;
        if (pkt_count !== 16'(exp_pkts)) begin
            n_fail++; $display("FAIL rnd_pkts: got %0d required %0d", pkt_count, exp_pkts);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        mode   = 2'd0;
        seed   = '0;
        plen   = 8'd1;
        tready = 1'b1;
        test_reset;
        test_counter;
        test_lfsr;
        test_backpressure;
        test_enable_drop;
        test_walk_and_zero_len;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_multi_pattern_generator.md
# axis_multi_pattern_generator

Parametrised AXI-Stream master pattern source with packet framing and an internal output FIFO. It is the next generation of the team's generator/FIFO wrapper. It adds selectable data patterns, programmable packet length, and clean stop on a packet boundary. Downstream consumers receive framed packets with full backpressure tolerance and no data loss or duplication.

## Interface
- DATA_SIZE, 32, tdata width in bits; must be a multiple of 8
- ADDR_WIDTH, 4, FIFO address width; depth is 2**ADDR_WIDTH words
- PKT_LEN_WIDTH, 8, width of the packet-length input
- LFSR_TAPS, 32'h80200003, Galois LFSR feedback mask; low DATA_SIZE bits are used

Ports:
- m00_axis_aclk  in  1  single clock
- m00_axis_areset  in  1  reset; synchronous, active-high
- m00_axis_enable  in  1  run request
- m00_axis_mode  in  2  pattern: 0 counter, 1 LFSR, 2 walking-one, 3 constant
- m00_axis_seed  in  DATA_SIZE  start value for counter, LFSR and constant modes
- m00_axis_pkt_len  in  PKT_LEN_WIDTH  beats per packet; 0 is treated as 1
- m00_axis_tready  in  1  downstream ready
- m00_axis_tdata  out  DATA_SIZE  stream data
- m00_axis_tstrb  out  DATA_SIZE/8  always all ones
- m00_axis_tvalid  out  1  FIFO not empty
- m00_axis_tlast  out  1  last beat of packet
- m00_axis_fifo_level  out  ADDR_WIDTH+1  current FIFO occupancy
- m00_axis_pkt_count  out  16  packets fully accepted downstream; wraps at 65535

## Operation
- Generator FSM states:
  - IDLE: on enable=1 → LOAD.
  - LOAD: takes one cycle. Latches mode and pkt_len. Initialises the pattern register on the first packet after reset or IDLE. Goes to RUN.
  - RUN: writes one beat per cycle while FIFO is not full. On the write of beat pkt_len-1: if enable=1 → LOAD; else → IDLE.
- Enable deasserting mid-packet never truncates; the current packet always completes.
- Mode and pkt_len changes take effect only in LOAD. Pattern state continues across packets.
- Pattern rules; every update happens only on an accepted FIFO write:
  - Counter: seed, seed+1, …; wraps modulo 2**DATA_SIZE.
  - LFSR: next = (v>>1) ^ (v[0] ? LFSR_TAPS : 0). A seed of 0 is replaced by 1.
  - Walking-one: starts at 1 and rotates left by 1 each beat.
  - Constant: seed on every beat.
- FIFO stores {tlast, tdata}. It is first-word-fall-through: tvalid = !empty, and tdata/tlast come from the head entry.
- Write is gated by !full only. Read occurs on tvalid & tready. Simultaneous read and write leaves the level unchanged.
- pkt_count increments on the handshake of a beat with tlast=1.

## Timing
- Reset values: tvalid 0, tdata 0, tlast 0, tstrb all ones, fifo_level 0, pkt_count 0. FSM goes to IDLE and FIFO pointers to 0.
- Reset mid-operation:
  - FIFO contents are discarded; tvalid is 0 on the cycle after reset is sampled.
  - The next packet restarts from seed.
- Latency:
  - enable is sampled high in cycle N.
  - LOAD is in cycle N+1.
  - The first write happens at the edge ending N+2.
  - tvalid=1 in cycle N+3.
- Sustained throughput: 1 beat/cycle with tready=1. There is no bubble between packets except the LOAD cycle.
- Full: the generator stalls with pattern and beat counter held. Level saturates at 2**ADDR_WIDTH.
- Empty: tvalid=0, and tdata holds its last value.
- While tvalid=1 and tready=0, tdata and tlast are stable.

## Structure
- Shared package holds:
  - mode encodings: MODE_CNT, MODE_LFSR, MODE_WALK, MODE_CONST
  - FSM state typedef: IDLE/LOAD/RUN
  - default LFSR_TAPS constant
- Sub-module axis_sync_fifo: parametrised by width and ADDR_WIDTH, with FWFT output and a level output. The top level contains the FSM, pattern register, beat counter and packet counter.

## Test plan
- Counter mode, seed=5, pkt_len=4, tready=1, enable pulsed for one cycle → tdata 5,6,7,8 with tlast on 8 → IDLE; pkt_count=1.
- LFSR mode, seed=1, pkt_len=3 → tdata 0x80200003, 0xC0300002, then the next LFSR value with tlast. seed=0 gives the same sequence.
- ADDR_WIDTH=4, counter mode, tready=0 for 30 cycles → fifo_level=16, tvalid=1, tdata stable. On release with tready=1, all beats arrive in order with no gaps or duplicates.
- pkt_len=8, enable dropped during beat 2 → exactly 8 beats, tlast on beat 8, then no further writes.
- Reset asserted at beat 3 of a 6-beat packet → next cycle tvalid=0, fifo_level=0, pkt_count=0. After re-enable, tdata restarts at seed.
- Walking-one with DATA_SIZE=8, pkt_len=10 → 01,02,04,…,80,01,02 with tlast on the 10th beat. pkt_len=0 → single-beat packets, each with tlast=1.
